// File: rtl/cmd_bus_arbiter_if.sv
// cmd_bus_arbiter_if: requester handshake and shared command-bus signals
interface cmd_bus_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid, req_rd, req_wr, req_ack, grant;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]      req_rdata, cmd_bus_data, cmd_bus_rdata;
    logic [ADDR_W-1:0]      cmd_bus_addr;
    logic                   cmd_bus_en, cmd_bus_rd, cmd_bus_wr;
    modport slave (
        input  req_valid, req_rd, req_wr, req_addr, req_data, cmd_bus_rdata,
        output req_ack, req_rdata, grant, cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_rd, cmd_bus_wr
    );
    modport master (
        output req_valid, req_rd, req_wr, req_addr, req_data, cmd_bus_rdata,
        input  req_ack, req_rdata, grant, cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_rd, cmd_bus_wr
    );
endinterface

// File: rtl/cmd_bus_arbiter.sv
// cmd_bus_arbiter: round-robin command-bus arbiter with optional requester-0 priority
module cmd_bus_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2,
    parameter int PRIO0      = 1
) (
    input logic              clk,
    input logic              rst,
    cmd_bus_arbiter_if.slave b
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, win;
    logic [3:0]        cnt_q, cnt_d;
    logic              rdop_q, rdop_d, any, w_rd, w_wr;
    logic              en_q, en_d, rd_q, rd_d, wr_q, wr_d;
    logic [NREQ-1:0]   grant_q, grant_d, ack_q, ack_d, onehot;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
    int                s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rdop_q  <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rdop_q  <= rdop_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // descending scan so the lowest offset from ptr is the last to match
    always_comb begin
        win = '0;
        s   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            s = int'(ptr_q) + i;
            s = (s >= NREQ) ? s - NREQ : s;
            if (b.req_valid[s]) win = PW'(s);
        end
        if (PRIO0 != 0 && b.req_valid[0]) win = '0;
        any    = |b.req_valid;
        w_rd   = b.req_rd[win];
        w_wr   = b.req_wr[win];
        onehot = NREQ'(1) << win;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rdop_d  = rdop_q;
        if (state_q == IDLE && any) begin
            state_d = ISSUE;
            ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            rdop_d  = w_rd & ~w_wr;
        end
        if (state_q == ISSUE) begin
            state_d = rdop_q ? RD_WAIT : IDLE;
            cnt_d   = 4'(RD_LATENCY);
        end
        if (state_q == RD_WAIT) begin
            state_d = (cnt_q == 4'd0) ? IDLE : RD_WAIT;
            cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 1'b1;
        end
    end

    // outputs are computed one cycle ahead so every port comes straight from a flop
    always_comb begin
        grant_d = grant_q;
        ack_d   = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        en_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        if (state_q == IDLE) begin
            grant_d = any ? onehot : '0;
            if (any) begin
                addr_d = b.req_addr[int'(win) * ADDR_W +: ADDR_W];
                data_d = b.req_data[int'(win) * DATA_W +: DATA_W];
                en_d   = w_rd | w_wr;
                wr_d   = w_wr;
                rd_d   = w_rd & ~w_wr;
                ack_d  = (w_rd & ~w_wr) ? '0 : onehot;
            end
        end
        if (state_q == ISSUE && !rdop_q) grant_d = '0;
        if (state_q == RD_WAIT) begin
            ack_d   = (cnt_q == 4'd1) ? grant_q : '0;
            rdata_d = (cnt_q == 4'd1) ? b.cmd_bus_rdata : rdata_q;
            grant_d = (cnt_q == 4'd0) ? '0 : grant_q;
        end
    end

    assign b.grant        = grant_q;
    assign b.req_ack      = ack_q;
    assign b.req_rdata    = rdata_q;
    assign b.cmd_bus_addr = addr_q;
    assign b.cmd_bus_data = data_q;
    assign b.cmd_bus_en   = en_q;
    assign b.cmd_bus_rd   = rd_q;
    assign b.cmd_bus_wr   = wr_q;
endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// tb_cmd_bus_arbiter: table-driven scoreboard bench for round-robin and priority arbiters
module tb_cmd_bus_arbiter;
    localparam int NREQ = 3, AW = 19, DW = 32, LAT = 2;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    valid = '0, rdv = '0, wrv = '0;
    logic [NREQ*AW-1:0] addrv = '0;
    logic [NREQ*DW-1:0] datav = '0;
    logic [DW-1:0]      bus_rdata = '0, chip_val = '0;

    cmd_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) b0 ();
    cmd_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) b1 ();
    assign b0.req_valid = valid;
    assign b0.req_rd = rdv;
    assign b0.req_wr = wrv;
    assign b0.req_addr = addrv;
    assign b0.req_data = datav;
    assign b0.cmd_bus_rdata = bus_rdata;
    assign b1.req_valid = valid;
    assign b1.req_rd = rdv;
    assign b1.req_wr = wrv;
    assign b1.req_addr = addrv;
    assign b1.req_data = datav;
    assign b1.cmd_bus_rdata = bus_rdata;

    cmd_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .PRIO0(0))
        u0 (.clk(clk), .rst(rst), .b(b0));
    cmd_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .PRIO0(1))
        u1 (.clk(clk), .rst(rst), .b(b1));

    typedef struct {
        int          req;
        bit          rd, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data, ret;
        bit          en, srd, swr;
        int          lat;
    } vec_t;
    vec_t tbl[8];
    vec_t q[$];

    int tests = 0, fails = 0, cyc = 0, cd = 0;
    bit sb_en = 1'b0, got;
    logic s_en = 1'b0, s_rd = 1'b0, s_wr = 1'b0;
    logic [AW-1:0] s_addr = '0;
    int s_cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // chip model: read data is valid only on the cycle RD_LATENCY after the strobe
    always @(negedge clk) begin
        bus_rdata <= {16'hBAD0, 16'(cyc)};
        if (b1.cmd_bus_rd) cd <= LAT;
        else if (cd == 1) begin
            cd <= 0;
            bus_rdata <= chip_val;
        end else if (cd != 0) cd <= cd - 1;
    end

    always @(negedge clk) begin : mon
        vec_t e;
        if (rst && sb_en) begin
            if (b1.cmd_bus_en | b1.cmd_bus_rd | b1.cmd_bus_wr) begin
                s_en <= b1.cmd_bus_en;
                s_rd <= b1.cmd_bus_rd;
                s_wr <= b1.cmd_bus_wr;
                s_addr <= b1.cmd_bus_addr;
                s_cyc <= cyc;
            end
            if (b1.req_ack != '0) begin
                if (q.size() == 0) chk("spurious_ack", 64'(b1.req_ack), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("ack", 64'(b1.req_ack), 64'(1) << e.req);
                    chk("grant_at_ack", 64'(b1.grant), 64'(1) << e.req);
                    if (e.srd) begin
                        chk("rd_strobe", 64'({s_en, s_rd, s_wr}), 64'(3'b110));
                        chk("rd_addr", 64'(s_addr), 64'(e.addr));
                        chk("rd_latency", 64'(cyc - s_cyc), 64'(e.lat));
                        chk("rd_ack_nostrobe", 64'({b1.cmd_bus_en, b1.cmd_bus_rd, b1.cmd_bus_wr}), 64'(0));
                        chk("rdata", 64'(b1.req_rdata), 64'(e.ret));
                    end else begin
                        chk("strobe", 64'({b1.cmd_bus_en, b1.cmd_bus_rd, b1.cmd_bus_wr}),
                            64'({e.en, e.srd, e.swr}));
                        if (e.en) begin
                            chk("wr_addr", 64'(b1.cmd_bus_addr), 64'(e.addr));
                            chk("wr_data", 64'(b1.cmd_bus_data), 64'(e.data));
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        valid = '0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(vec_t v);
        @(negedge clk);
        valid = NREQ'(1) << v.req;
        rdv = v.rd ? valid : '0;
        wrv = v.wr ? valid : '0;
        addrv[v.req*AW +: AW] = v.addr;
        datav[v.req*DW +: DW] = v.data;
        chip_val = v.ret;
        q.push_back(v);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (b1.req_ack != '0);
        end
        chk("ack_seen", 64'(got), 64'(1));
        valid = '0;
        @(negedge clk);
        chk("idle_after_ack", 64'({b1.grant, b1.cmd_bus_en, b1.cmd_bus_rd, b1.cmd_bus_wr}), 64'(0));
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 1'b1, 19'h00010, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1'b1, 0};
        tbl[1] = '{1, 1'b1, 1'b0, 19'h7FFFF, 32'h0,        32'h12345678, 1'b1, 1'b1, 1'b0, LAT + 1};
        tbl[2] = '{2, 1'b0, 1'b1, 19'h55555, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b0, 1'b1, 0};
        tbl[3] = '{2, 1'b1, 1'b0, 19'h00000, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, LAT + 1};
        tbl[4] = '{1, 1'b1, 1'b1, 19'h12345, 32'h0BADF00D, 32'h0,        1'b1, 1'b0, 1'b1, 0};
        tbl[5] = '{0, 1'b0, 1'b0, 19'h00ABC, 32'h11111111, 32'h0,        1'b0, 1'b0, 1'b0, 0};
        tbl[6] = '{0, 1'b1, 1'b0, 19'h40000, 32'h0,        32'h80000001, 1'b1, 1'b1, 1'b0, LAT + 1};
        tbl[7] = '{1, 1'b0, 1'b1, 19'h7FFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b1, 0};

        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({b1.grant, b1.req_ack, b1.cmd_bus_en, b1.cmd_bus_rd, b1.cmd_bus_wr}), 64'(0));
        chk("reset_bus", 64'({b1.cmd_bus_addr, b1.req_rdata}), 64'(0));
        chk("reset_grant_rr", 64'(b0.grant), 64'(0));
        rst = 1'b1;

        sb_en = 1'b1;
        for (int i = 0; i < 8; i++) run(tbl[i]);
        sb_en = 1'b0;

        // pure round-robin with all three writes held
        do_reset();
        @(negedge clk);
        valid = '1;
        wrv = '1;
        rdv = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(b0.grant), (k % 2 == 1) ? 64'(1) << (((k - 1) / 2) % 3) : 64'(0));
            chk("rr_strobe", 64'({b0.cmd_bus_en, b0.cmd_bus_wr}), (k % 2 == 1) ? 64'(3) : 64'(0));
        end
        valid = '0;

        // requester 0 priority starves requester 2 until it drops
        do_reset();
        @(negedge clk);
        valid = 3'b101;
        wrv = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("prio_grant", 64'(b1.grant), (k % 2 == 1) ? 64'(1) : 64'(0));
        end
        valid = 3'b100;
        @(negedge clk);
        chk("prio_release", 64'(b1.grant), 64'(3'b100));
        valid = '0;
        @(negedge clk);
        chk("prio_idle", 64'(b1.grant), 64'(0));

        // reset in the middle of a read drops it without an ack
        sb_en = 1'b1;
        @(negedge clk);
        valid = 3'b010;
        rdv = 3'b010;
        wrv = '0;
        addrv[AW +: AW] = 19'h7FFFF;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = b1.cmd_bus_rd;
        end
        chk("rst_rd_strobe", 64'(got), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        valid = '0;
        @(negedge clk);
        chk("rst_mid_ctrl", 64'({b1.grant, b1.req_ack, b1.cmd_bus_en, b1.cmd_bus_rd, b1.cmd_bus_wr}), 64'(0));
        chk("rst_mid_bus", 64'({b1.cmd_bus_addr, b1.req_rdata}), 64'(0));
        chk("rst_mid_data", 64'(b1.cmd_bus_data), 64'(0));
        rst = 1'b1;
        repeat (6) @(negedge clk);
        sb_en = 1'b0;
        valid = '1;
        wrv = '1;
        rdv = '0;
        @(negedge clk);
        chk("rst_ptr_rr", 64'(b0.grant), 64'(1));
        chk("rst_ptr_prio", 64'(b1.grant), 64'(1));
        valid = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
